systolic_result_drain: RTL and testbench

//   Downstream stage of the systolic matrix multiplier. On the array's single-cycle done

---
 rtl/systolic_result_drain.sv | 150 +++++++++++++++
 tb/tb_systolic_result_drain.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_drain.sv
// Snapshots the systolic array's MxN accumulator matrix on done_in, requantises each element, and streams it out row-major.
// Latency: the first beat is valid the cycle after done_in, then one beat per cycle while out_ready is held high.
// Backpressure: out_ready low stalls the beat with every out_* field held; a done_in that arrives mid-drain is dropped and flagged in overrun.
module systolic_result_drain #(
  parameter  int M         = 6,
  parameter  int N         = 6,
  parameter  int ACC_WIDTH = 35,
  parameter  int OUT_WIDTH = 16,
  parameter  int SHIFT     = 8,
  localparam int ROW_W     = (M > 1) ? $clog2(M) : 1,
  localparam int COL_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       done_in,
  input  logic [M*N*ACC_WIDTH-1:0]   C_flat,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic [ROW_W-1:0]           out_row,
  output logic [COL_W-1:0]           out_col,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       overrun,
  output logic [15:0]                sat_cnt
);

  localparam int TOT    = M * N;
  localparam int IDX_W  = (TOT > 1) ? $clog2(TOT) : 1;
  // One extra bit so adding the rounding constant can never wrap.
  localparam int XW     = ACC_WIDTH + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [XW-1:0] RND   = (SHIFT > 0) ? (XW'(1) << RND_SH) : '0;
  localparam logic signed [XW-1:0] MAX_V = {{(XW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] MIN_V = {{(XW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] snap [TOT];
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_nx;
  logic                 cur_sat_q;
  logic                 xfer;
  logic                 last_xfer;
  logic                 capture;
  logic                 ovr_set;
  logic [OUT_WIDTH:0]   rq_first;
  logic [OUT_WIDTH:0]   rq_next;

  // Round half up, arithmetic shift, then clamp. Returns {saturated, value}.
  function automatic logic [OUT_WIDTH:0] requant(input logic [ACC_WIDTH-1:0] x);
    logic signed [XW-1:0] xe;
    logic signed [XW-1:0] y;
    logic [OUT_WIDTH:0]   r;
    xe = $signed({x[ACC_WIDTH-1], x});
    y  = (xe + RND) >>> SHIFT;
    if (y > MAX_V)      r = {1'b1, MAX_V[OUT_WIDTH-1:0]};
    else if (y < MIN_V) r = {1'b1, MIN_V[OUT_WIDTH-1:0]};
    else                r = {1'b0, y[OUT_WIDTH-1:0]};
    return r;
  endfunction

  // Every output is decoded from registered state only.
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN);
  assign out_last  = out_valid && (idx_q == IDX_W'(TOT - 1));
  assign idx_nx    = idx_q + IDX_W'(1);
  // Element 0 comes straight from C_flat because the snapshot is only written at the same edge.
  assign rq_first  = requant(C_flat[ACC_WIDTH-1:0]);
  assign rq_next   = requant(snap[idx_nx]);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the capture, transfer and overrun strobes. A done_in that lands on the final transfer is accepted.
  always_comb begin
    state_d   = state_q;
    xfer      = 1'b0;
    last_xfer = 1'b0;
    capture   = 1'b0;
    ovr_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (done_in) begin
          capture = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        xfer      = out_ready;
        last_xfer = out_ready && (idx_q == IDX_W'(TOT - 1));
        if (done_in && last_xfer) begin
          capture = 1'b1;
        end else begin
          ovr_set = done_in;
          if (last_xfer) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot storage. Its contents are don't-care after reset, so it has no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < TOT; i++) begin
        snap[i] <= C_flat[i*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  // Presented-beat registers, index walk, saturation counter and sticky overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q     <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_data  <= '0;
      cur_sat_q <= 1'b0;
      sat_cnt   <= '0;
      overrun   <= 1'b0;
    end else begin
      if (ovr_set) overrun <= 1'b1;
      if (xfer && cur_sat_q && (sat_cnt != 16'hFFFF)) sat_cnt <= sat_cnt + 16'd1;
      if (capture) begin
        idx_q     <= '0;
        out_row   <= '0;
        out_col   <= '0;
        out_data  <= rq_first[OUT_WIDTH-1:0];
        cur_sat_q <= rq_first[OUT_WIDTH];
        sat_cnt   <= '0;
      end else if (xfer && !last_xfer) begin
        idx_q     <= idx_nx;
        out_data  <= rq_next[OUT_WIDTH-1:0];
        cur_sat_q <= rq_next[OUT_WIDTH];
        if (out_col == COL_W'(N - 1)) begin
          out_col <= '0;
          out_row <= out_row + ROW_W'(1);
        end else begin
          out_col <= out_col + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomised scoreboard bench for systolic_result_drain.
module tb_systolic_result_drain;

  localparam int M   = 6;
  localparam int N   = 6;
  localparam int AW  = 35;
  localparam int OW  = 16;
  localparam int SH  = 8;
  localparam int TOT = M * N;

  typedef struct {
    longint d;
    int     r;
    int     c;
    int     last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              done_in = 1'b0;
  logic              out_ready = 1'b0;
  logic [TOT*AW-1:0] c_flat = '0;
  logic [OW-1:0]     out_data;
  logic [2:0]        out_row;
  logic [2:0]        out_col;
  logic              out_last;
  logic              out_valid;
  logic              busy;
  logic              overrun;
  logic [15:0]       sat_cnt;

  int     pass_cnt = 0;
  int     chk_cnt  = 0;
  beat_t  exp_q[$];
  longint cm[TOT];
  int     exp_sat = 0;
  bit     rdy_rand = 1'b0;

  systolic_result_drain #(.M(M), .N(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n), .done_in(done_in), .C_flat(c_flat),
    .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .overrun(overrun),
    .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Reference requantiser: floor((x + 2^SH/2) / 2^SH), clamped to the OW-bit signed range.
  function automatic longint model_q(input longint x, output bit sat);
    longint d;
    longint v;
    longint y;
    d = longint'(1) << SH;
    v = x + d / 2;
    y = (v >= 0) ? v / d : -((-v + d - 1) / d);
    sat = 1'b0;
    if (y > 32767) begin
      y = 32767; sat = 1'b1;
    end else if (y < -32768) begin
      y = -32768; sat = 1'b1;
    end
    return y;
  endfunction

  task automatic pack_cflat();
    for (int i = 0; i < TOT; i++) c_flat[i*AW +: AW] = AW'(cm[i]);
  endtask

  task automatic rand_matrix();
    logic [63:0]          r;
    logic signed [AW-1:0] t;
    for (int i = 0; i < TOT; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          r = {$urandom, $urandom};
          t = r[AW-1:0];
          cm[i] = t;
        end
        1: cm[i] = longint'($urandom_range(0, 16777216)) - 8388608;
        2: begin
          if ($urandom_range(0, 1) == 1) cm[i] = 8388480 + longint'($urandom_range(0, 600)) - 300;
          else                           cm[i] = -8388736 + longint'($urandom_range(0, 600)) - 300;
        end
        default: cm[i] = longint'($urandom_range(0, 2000)) - 1000;
      endcase
    end
    pack_cflat();
  endtask

  // Queue the expected beats of the matrix in cm and compute its saturation count.
  task automatic push_frame();
    beat_t b;
    bit    s;
    exp_sat = 0;
    pack_cflat();
    for (int i = 0; i < TOT; i++) begin
      b.d    = model_q(cm[i], s);
      b.r    = i / N;
      b.c    = i % N;
      b.last = (i == TOT - 1) ? 1 : 0;
      exp_q.push_back(b);
      if (s) exp_sat++;
    end
  endtask

  task automatic issue_done();
    done_in = 1'b1;
    @(posedge clk);
    #1;
    done_in = 1'b0;
  endtask

  task automatic start_frame();
    push_frame();
    issue_done();
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({name, "_drain_in_time"}, (k < 3000) ? 1 : 0, 1);
    check({name, "_sat_cnt"}, sat_cnt, exp_sat);
  endtask

  task automatic wait_beat(input int r, input int c);
    int k;
    k = 0;
    while (!(out_valid && out_row == 3'(r) && out_col == 3'(c)) && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("beat_reached", (k < 500) ? 1 : 0, 1);
  endtask

  // Consumer: either always ready or randomly stalling.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks stability while stalled.
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic        prev_last = 1'b0;
  logic [15:0] prev_d = '0;
  logic [2:0]  prev_row = '0;
  logic [2:0]  prev_col = '0;
  beat_t       e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_d);
        check("stall_row", out_row, prev_row);
        check("stall_col", out_col, prev_col);
        check("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", longint'($signed(out_data)), e.d);
          check("beat_row", out_row, e.r);
          check("beat_col", out_col, e.c);
          check("beat_last", out_last, e.last);
        end
      end
      prev_v    = out_valid;
      prev_r    = out_ready;
      prev_d    = out_data;
      prev_row  = out_row;
      prev_col  = out_col;
      prev_last = out_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // T1: reset held with done_in asserted
    rand_matrix();
    rst_n   = 1'b0;
    done_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_col", out_col, 0);
    check("rst_out_last", out_last, 0);
    done_in = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_busy", busy, 0);

    // T2: ramp 0..35, continuous ready, one beat per cycle
    for (int i = 0; i < TOT; i++) cm[i] = longint'(i) * 256;
    start_frame();
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (busy && k < 100);
    check("t2_frame_cycles", k, TOT);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_sat_cnt", sat_cnt, 0);

    // T4: rounding and saturation corners
    for (int i = 0; i < TOT; i++) cm[i] = 0;
    cm[0] = 383;
    cm[1] = -384;
    cm[2] = longint'(1) << 30;
    cm[3] = -(longint'(1) << 30);
    start_frame();
    wait_idle("t4");
    check("t4_sat_cnt_is_2", sat_cnt, 2);

    // T3: random backpressure over several random frames
    rdy_rand = 1'b1;
    repeat (4) begin
      rand_matrix();
      start_frame();
      wait_idle("t3");
    end
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // T5: dropped done_in mid-frame, then done_in on the last transfer
    rand_matrix();
    start_frame();
    wait_beat(1, 4);
    rand_matrix();
    issue_done();
    check("t5_overrun_set", overrun, 1);
    check("t5_busy", busy, 1);
    k = 0;
    while (!(out_valid && out_last) && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("t5_last_reached", (k < 500) ? 1 : 0, 1);
    rand_matrix();
    start_frame();
    check("t5_no_bubble_valid", out_valid, 1);
    check("t5_restart_row", out_row, 0);
    check("t5_restart_col", out_col, 0);
    check("t5_sat_cleared", sat_cnt, 0);
    wait_idle("t5");
    check("t5_overrun_sticky", overrun, 1);

    // T6: reset in the middle of a drain, then a fresh frame
    rand_matrix();
    start_frame();
    wait_beat(3, 2);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("t6_valid_dropped", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_overrun_cleared", overrun, 0);
    check("t6_sat_cleared", sat_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_still_idle", out_valid, 0);
    rand_matrix();
    start_frame();
    check("t6_restart_valid", out_valid, 1);
    check("t6_restart_row", out_row, 0);
    check("t6_restart_col", out_col, 0);
    wait_idle("t6");

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    check("final_idle", out_valid, 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
